// File: rtl/brus16_sdp_ram.sv
// Simple-dual-port byte-enable RAM with write-first forwarding and a busy-gated zeroing engine.
// Read latency 1+OUT_REG; no backpressure, user reads/writes are dropped while busy.
// Optional per-lane even parity with read-side error flag: define BRUS16_SDP_RAM_PARITY_EN.
module brus16_sdp_ram #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 13,
    parameter int BYTE_W         = 8,
    parameter int OUT_REG        = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/BYTE_W-1:0]   wr_be,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       clr_req,
    output logic                       busy
`ifdef BRUS16_SDP_RAM_PARITY_EN
    ,output logic                      rd_perr
`endif
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_busy  <= (CLEAR_ON_RESET != 0);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (&r_cnt) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = r_busy;

    // The clear engine owns the single write port for the whole clear.
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [NB-1:0]     w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdat;

    assign w_wr_acc = wr_en & ~r_busy;
    assign w_rd_acc = rd_en & ~r_busy;
    assign w_we     = r_busy ? {NB{1'b1}} : (wr_be & {NB{wr_en}});
    assign w_waddr  = r_busy ? r_cnt : wr_addr;
    assign w_wdat   = r_busy ? '0 : wr_data;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_we[i]) r_mem[w_waddr][i*BYTE_W +: BYTE_W] <= w_wdat[i*BYTE_W +: BYTE_W];
        end
    end

    // Stage 1: array read (old data) plus the lanes a same-cycle write must override.
    logic              r_v1;
    logic [DATA_W-1:0] r_q1;
    logic [NB-1:0]     r_col_be;
    logic [DATA_W-1:0] r_col_dat;
    logic [DATA_W-1:0] w_m1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v1      <= 1'b0;
            r_q1      <= '0;
            r_col_be  <= '0;
            r_col_dat <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_q1      <= r_mem[rd_addr];
                r_col_be  <= (w_wr_acc && (wr_addr == rd_addr)) ? wr_be : '0;
                r_col_dat <= wr_data;
            end
        end
    end

    always_comb begin
        w_m1 = r_q1;
        for (int i = 0; i < NB; i++) begin
            if (r_col_be[i]) w_m1[i*BYTE_W +: BYTE_W] = r_col_dat[i*BYTE_W +: BYTE_W];
        end
    end

`ifdef BRUS16_SDP_RAM_PARITY_EN
    logic [NB-1:0] r_pmem [DEPTH];
    logic [NB-1:0] w_wpar;
    logic [NB-1:0] r_p1;
    logic [NB-1:0] w_cpar;
    logic [NB-1:0] w_mp1;
    logic          w_perr1;

    always_comb begin
        w_wpar = '0;
        w_cpar = '0;
        w_mp1  = '0;
        for (int i = 0; i < NB; i++) begin
            w_wpar[i] = ^w_wdat[i*BYTE_W +: BYTE_W];
            w_cpar[i] = ^w_m1[i*BYTE_W +: BYTE_W];
            w_mp1[i]  = r_col_be[i] ? w_cpar[i] : r_p1[i];
        end
    end

    assign w_perr1 = |(w_mp1 ^ w_cpar);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_we[i]) r_pmem[w_waddr][i] <= w_wpar[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       r_p1 <= '0;
        else if (w_rd_acc) r_p1 <= r_pmem[rd_addr];
    end
`else
    logic w_perr1;
    assign w_perr1 = 1'b0;
`endif

    logic w_perr_out;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_v2;
            logic [DATA_W-1:0] r_q2;
            logic              r_perr2;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_v2    <= 1'b0;
                    r_q2    <= '0;
                    r_perr2 <= 1'b0;
                end else begin
                    r_v2    <= r_v1;
                    r_perr2 <= r_v1 & w_perr1;
                    if (r_v1) r_q2 <= w_m1;
                end
            end

            assign rd_data    = r_q2;
            assign rd_valid   = r_v2;
            assign w_perr_out = r_perr2;
        end else begin : g_no_out_reg
            assign rd_data    = w_m1;
            assign rd_valid   = r_v1;
            assign w_perr_out = r_v1 & w_perr1;
        end
    endgenerate

`ifdef BRUS16_SDP_RAM_PARITY_EN
    assign rd_perr = w_perr_out;
`else
    logic w_unused;
    assign w_unused = w_perr_out;
`endif

endmodule

// File: tb/tb_brus16_sdp_ram.sv
// Directed bench for brus16_sdp_ram (DATA_W=16, ADDR_W=4, OUT_REG=1, CLEAR_ON_RESET=1).
module tb_brus16_sdp_ram;
    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        clr_req;
    logic        busy;
`ifdef BRUS16_SDP_RAM_PARITY_EN
    logic        rd_perr;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    brus16_sdp_ram #(
        .DATA_W(16), .ADDR_W(4), .BYTE_W(8), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .clr_req  (clr_req),
        .busy     (busy)
`ifdef BRUS16_SDP_RAM_PARITY_EN
        ,.rd_perr (rd_perr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at a negedge with the write retired.
    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        wr_en = 1'b0; wr_be = 2'b00;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string tag,
                      input logic pexp = 1'b0);
        rd_en = 1'b1; rd_addr = a;
        @(negedge clk);
        rd_en = 1'b0;
        check({tag, "_early"}, rd_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, exp);
`ifdef BRUS16_SDP_RAM_PARITY_EN
        check({tag, "_perr"}, rd_perr, pexp);
`else
        if (pexp) $display("note: parity expectation ignored for %s", tag);
`endif
    endtask

    function automatic logic [15:0] fillpat(input int i);
        return 16'((i * 16'h0101) ^ 16'h5AC3);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int nb;
        int nv;
        logic [15:0] vdat;

        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0; clr_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 1);

        // Power-up clear: busy for exactly 16 cycles after release.
        resetn = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (busy && n < 100);
        check("init_clear_cycles", n, 16);
        @(negedge clk);
        for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000, "init_zero");

        // Byte-lane writes.
        wr(4'd3, 16'hBEEF, 2'b11);
        wr(4'd3, 16'h1234, 2'b01);
        rd(4'd3, 16'hBE34, "be_merge");
        wr(4'd3, 16'hFFFF, 2'b00);
        rd(4'd3, 16'hBE34, "be_zero_noop");

        // Same-cycle write/read at one address: upper lane forwarded, lower lane old.
        wr(4'd5, 16'h1111, 2'b11);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hAA55; wr_be = 2'b10;
        rd_en = 1'b1; rd_addr = 4'd5;
        @(negedge clk);
        wr_en = 1'b0; wr_be = 2'b00; rd_en = 1'b0;
        check("col_early", rd_valid, 0);
        @(negedge clk);
        check("col_valid", rd_valid, 1);
        check("col_data", rd_data, 16'hAA11);
        rd(4'd5, 16'hAA11, "col_after");

        // Back-to-back reads, then hold while idle.
        rd_en = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        rd_addr = 4'd5;
        @(negedge clk);
        rd_en = 1'b0;
        check("b2b_v0", rd_valid, 1);
        check("b2b_d0", rd_data, 16'hBE34);
        @(negedge clk);
        check("b2b_v1", rd_valid, 1);
        check("b2b_d1", rd_data, 16'hAA11);
        @(negedge clk);
        check("hold_valid", rd_valid, 0);
        check("hold_data", rd_data, 16'hAA11);

        // Fill, then clear while hammering the ports; one read is accepted just before busy.
        for (int i = 0; i < 16; i++) wr(4'(i), fillpat(i), 2'b11);
        clr_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd7;
        @(negedge clk);
        nb = 0; nv = 0; vdat = '0;
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            nb++;
            if (rd_valid) begin nv++; vdat = rd_data; end
            clr_req = (nb == 5);
            rd_en = 1'b1; rd_addr = nb[3:0];
            wr_en = 1'b1; wr_addr = nb[3:0]; wr_data = 16'hFFFF; wr_be = 2'b11;
            @(negedge clk);
        end
        clr_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0; wr_be = 2'b00;
        check("clr_busy_cycles", nb, 16);
        check("clr_valid_count", nv, 1);
        check("clr_preclear_read", vdat, fillpat(7));
        for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000, "clr_zero");

        // Reset while a result is being presented.
        wr(4'd9, 16'h9999, 2'b11);
        rd_en = 1'b1; rd_addr = 4'd9;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", rd_valid, 1);
        check("pre_rst_data", rd_data, 16'h9999);
        resetn = 1'b0;
        #1;
        check("async_rst_valid", rd_valid, 0);
        check("async_rst_data", rd_data, 0);
        check("async_rst_busy", busy, 1);
        @(negedge clk);
        resetn = 1'b1;

        // Reset with the clear counter at 7, then a full restart.
        repeat (7) @(posedge clk);
        #1;
        check("mid_clear_busy", busy, 1);
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1);
        check("mid_rst_valid", rd_valid, 0);
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (busy && n < 100);
        check("restart_clear_cycles", n, 16);
        @(negedge clk);
        rd(4'd0, 16'h0000, "restart_a0");
        rd(4'd9, 16'h0000, "restart_a9");
        rd(4'd15, 16'h0000, "restart_a15");

`ifdef BRUS16_SDP_RAM_PARITY_EN
        wr(4'd2, 16'h00FF, 2'b11);
        wr(4'd4, 16'h0F01, 2'b11);
        dut.r_mem[2] = dut.r_mem[2] ^ 16'h0001;
        rd(4'd2, 16'h00FE, "par_flip", 1'b1);
        rd(4'd4, 16'h0F01, "par_clean", 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
